// File: rtl/reg_file.sv
// Two-read, one-write register file with per-entry valid bits, a count of
// valid entries, optional write-to-read forwarding and an optional hardwired zero register.
module reg_file #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 0,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic [DEPTH-1:0] valid,
    output logic [AW:0]      wr_count
);

    localparam logic BYPASS_EN = (BYPASS != 0);
    localparam logic ZERO_EN   = (ZERO_REG != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_zero;
    logic             wr_hit;

    // A write lands only when not cleared and not aimed at the hardwired zero entry.
    assign wr_zero = ZERO_EN && (waddr == AW'(0));
    assign wr_hit  = we && !clr && !reset && !wr_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            valid    <= '0;
            wr_count <= '0;
        end else if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            valid    <= '0;
            wr_count <= '0;
        end else if (wr_hit) begin
            mem[waddr]   <= wdata;
            valid[waddr] <= 1'b1;
            // Count only first writes; rewrites of a valid entry leave it alone.
            if (!valid[waddr]) begin
                wr_count <= wr_count + (AW+1)'(1);
            end
        end
    end

    always_comb begin
        rdata_a = valid[raddr_a] ? mem[raddr_a] : '0;
        if (BYPASS_EN && wr_hit && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
        if ((ZERO_EN && (raddr_a == AW'(0))) || reset) begin
            rdata_a = '0;
        end
    end

    always_comb begin
        rdata_b = valid[raddr_b] ? mem[raddr_b] : '0;
        if (BYPASS_EN && wr_hit && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
        if ((ZERO_EN && (raddr_b == AW'(0))) || reset) begin
            rdata_b = '0;
        end
    end

endmodule
